jtframe_sdram_arb: RTL and testbench

//  Shares one SDRAM bank port of the frame (baN_addr/ba_rd/ba_wr/ba_din/ba_dsn, ba_ack/ba_rdy,

---
 rtl/jtframe_arb_pkg.sv | 18 +
 rtl/jtframe_arb_rr.sv | 74 +++++++
 rtl/jtframe_sdram_arb.sv | 160 ++++++++++++++++
 tb/tb_jtframe_sdram_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_arb_pkg.sv
// ---------------------------------------------------------------------------
// jtframe_arb_pkg
// Shared definitions for the SDRAM bank arbiter (jtframe_sdram_arb) and its
// round-robin picker (jtframe_arb_rr).
//   arbState_t : arbiter FSM states IDLE -> ISSUE -> WAIT -> IDLE
//   DSN_NONE   : byte-strobe value with both bytes disabled (active low)
// ---------------------------------------------------------------------------
package jtframe_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arbState_t;

  localparam logic [1:0] DSN_NONE = 2'b11;

endpackage

// File: rtl/jtframe_arb_rr.sv
// ---------------------------------------------------------------------------
// jtframe_arb_rr
// Combinational round-robin picker for jtframe_sdram_arb.
// Searches i_last+1, i_last+2, ... (mod NCL) and returns the first requester.
// Optional feature macro: JTFRAME_ARB_PRIO0_EN
//   When defined, client 0 wins unless it was the last client granted, and
//   clients 1..NCL-1 rotate among themselves from their own pointer
//   i_rrLast. This lets client 0 interleave with every other client.
// Ports:
//   i_req    : request vector, one bit per client
//   i_last   : index of the last granted client
//   i_rrLast : (PRIO0 only) last granted client among 1..NCL-1
//   o_winner : index of the chosen client (meaningful when o_any=1)
//   o_any    : at least one client is requesting
// ---------------------------------------------------------------------------
module jtframe_arb_rr
  import jtframe_arb_pkg::*;
#(
  parameter int NCL = 4,
  parameter int GW  = $clog2(NCL)
) (
  input  logic [NCL-1:0] i_req,
  input  logic [GW-1:0]  i_last,
`ifdef JTFRAME_ARB_PRIO0_EN
  input  logic [GW-1:0]  i_rrLast,
`endif
  output logic [GW-1:0]  o_winner,
  output logic           o_any
);

  logic          w_found;
  logic [GW-1:0] w_idx;

  assign o_any = |i_req;

`ifdef JTFRAME_ARB_PRIO0_EN
  // Client 0 first unless it just had a turn; otherwise rotate over 1..NCL-1,
  // falling back to client 0 when nobody else is asking.
  always_comb begin
    o_winner = i_last;
    w_found  = 1'b0;
    w_idx    = '0;
    if (i_req[0] && (i_last != '0)) begin
      o_winner = '0;
      w_found  = 1'b1;
    end
    for (int k = 1; k <= NCL; k++) begin
      w_idx = GW'((int'(i_rrLast) + k) % NCL);
      if (!w_found && (w_idx != '0) && i_req[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
    if (!w_found && i_req[0]) begin
      o_winner = '0;
    end
  end
`else
  // Plain rotation: the client right after the last grant has top priority.
  always_comb begin
    o_winner = i_last;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 1; k <= NCL; k++) begin
      w_idx = GW'((int'(i_last) + k) % NCL);
      if (!w_found && i_req[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/jtframe_sdram_arb.sv
// ---------------------------------------------------------------------------
// jtframe_sdram_arb
// Shares one SDRAM bank port between NCL game-side clients. One transaction
// is in flight at a time; the winner's address/data/strobes are registered
// in IDLE and held on the bank port until the controller acknowledges.
// Optional feature macro: JTFRAME_ARB_PRIO0_EN (client 0 priority, see
// jtframe_arb_rr).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cl_req/cl_wr        : per-client request and write flag
//   cl_addr/cl_din/cl_dsn: per-client packed address, write data, strobes
//   cl_rdy              : one-cycle done pulse for the served client
//   cl_dout             : last read data, held until the next read completes
//   ba_addr/ba_rd/ba_wr/ba_din/ba_dsn : command to the bank port
//   ba_ack/ba_rdy       : controller accepted / transaction finished
//   sdram_dout          : read data from the controller
//   grant               : current or last granted client
//   busy                : arbiter is outside IDLE
// ---------------------------------------------------------------------------
module jtframe_sdram_arb
  import jtframe_arb_pkg::*;
#(
  parameter int NCL = 4,
  parameter int AW  = 22,
  parameter int DW  = 16,
  parameter int GW  = $clog2(NCL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCL-1:0]    cl_req,
  input  logic [NCL-1:0]    cl_wr,
  input  logic [NCL*AW-1:0] cl_addr,
  input  logic [NCL*DW-1:0] cl_din,
  input  logic [NCL*2-1:0]  cl_dsn,
  output logic [NCL-1:0]    cl_rdy,
  output logic [DW-1:0]     cl_dout,
  output logic [AW-1:0]     ba_addr,
  output logic              ba_rd,
  output logic              ba_wr,
  output logic [DW-1:0]     ba_din,
  output logic [1:0]        ba_dsn,
  input  logic              ba_ack,
  input  logic              ba_rdy,
  input  logic [DW-1:0]     sdram_dout,
  output logic [GW-1:0]     grant,
  output logic              busy
);

  arbState_t      r_state;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_din;
  logic [1:0]     r_dsn;
  logic           r_rd;
  logic           r_wr;
  logic           r_isWr;
  logic [NCL-1:0] r_rdy;
  logic [DW-1:0]  r_dout;
  logic [GW-1:0]  r_grant;
`ifdef JTFRAME_ARB_PRIO0_EN
  logic [GW-1:0]  r_rrPtr;
`endif

  logic [GW-1:0]  w_winner;
  logic           w_any;

  jtframe_arb_rr #(
    .NCL (NCL),
    .GW  (GW)
  ) u_rr (
    .i_req    (cl_req),
    .i_last   (r_grant),
`ifdef JTFRAME_ARB_PRIO0_EN
    .i_rrLast (r_rrPtr),
`endif
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Single FSM with registered outputs. While cl_rdy is pulsing the served
  // client has not yet had a chance to drop its request, so that IDLE cycle
  // never arbitrates; this also guarantees at least one IDLE cycle per
  // transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_din   <= '0;
      r_dsn   <= DSN_NONE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_isWr  <= 1'b0;
      r_rdy   <= '0;
      r_dout  <= '0;
      r_grant <= GW'(NCL - 1);
`ifdef JTFRAME_ARB_PRIO0_EN
      r_rrPtr <= GW'(NCL - 1);
`endif
    end else begin
      r_rdy <= '0;
      case (r_state)
        IDLE: begin
          if (w_any && (r_rdy == '0)) begin
            r_addr  <= cl_addr[int'(w_winner)*AW +: AW];
            r_din   <= cl_din[int'(w_winner)*DW +: DW];
            r_dsn   <= cl_dsn[int'(w_winner)*2 +: 2];
            r_isWr  <= cl_wr[w_winner];
            r_rd    <= ~cl_wr[w_winner];
            r_wr    <= cl_wr[w_winner];
            r_grant <= w_winner;
`ifdef JTFRAME_ARB_PRIO0_EN
            if (w_winner != '0) begin
              r_rrPtr <= w_winner;
            end
`endif
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (ba_ack) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            // A controller may finish in the same cycle it accepts.
            if (ba_rdy) begin
              if (!r_isWr) begin
                r_dout <= sdram_dout;
              end
              r_rdy[r_grant] <= 1'b1;
              r_state        <= IDLE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ba_rdy) begin
            if (!r_isWr) begin
              r_dout <= sdram_dout;
            end
            r_rdy[r_grant] <= 1'b1;
            r_state        <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ba_addr = r_addr;
  assign ba_din  = r_din;
  assign ba_dsn  = r_dsn;
  assign ba_rd   = r_rd;
  assign ba_wr   = r_wr;
  assign cl_rdy  = r_rdy;
  assign cl_dout = r_dout;
  assign grant   = r_grant;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// ---------------------------------------------------------------------------
// tb_jtframe_sdram_arb
// Directed bench for jtframe_sdram_arb (NCL=4, AW=22). Inputs change and
// outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_jtframe_sdram_arb;

  localparam int NCL = 4;
  localparam int AW  = 22;
  localparam int DW  = 16;

  logic              clk;
  logic              rst_n;
  logic [NCL-1:0]    cl_req;
  logic [NCL-1:0]    cl_wr;
  logic [NCL*AW-1:0] cl_addr;
  logic [NCL*DW-1:0] cl_din;
  logic [NCL*2-1:0]  cl_dsn;
  logic [NCL-1:0]    cl_rdy;
  logic [DW-1:0]     cl_dout;
  logic [AW-1:0]     ba_addr;
  logic              ba_rd;
  logic              ba_wr;
  logic [DW-1:0]     ba_din;
  logic [1:0]        ba_dsn;
  logic              ba_ack;
  logic              ba_rdy;
  logic [DW-1:0]     sdram_dout;
  logic [1:0]        grant;
  logic              busy;

  int nChecks = 0;
  int nPass   = 0;

  jtframe_sdram_arb #(
    .NCL (NCL),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cl_req     (cl_req),
    .cl_wr      (cl_wr),
    .cl_addr    (cl_addr),
    .cl_din     (cl_din),
    .cl_dsn     (cl_dsn),
    .cl_rdy     (cl_rdy),
    .cl_dout    (cl_dout),
    .ba_addr    (ba_addr),
    .ba_rd      (ba_rd),
    .ba_wr      (ba_wr),
    .ba_din     (ba_din),
    .ba_dsn     (ba_dsn),
    .ba_ack     (ba_ack),
    .ba_rdy     (ba_rdy),
    .sdram_dout (sdram_dout),
    .grant      (grant),
    .busy       (busy)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and step just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison: counts it, and on mismatch reports tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Set the request and write-flag vectors.
  task automatic applyStimulus(input logic [NCL-1:0] req, input logic [NCL-1:0] wr);
    cl_req = req;
    cl_wr  = wr;
  endtask

  // Wait (bounded) for a bank strobe to appear.
  task automatic waitStrobe(input string tag);
    int n;
    n = 0;
    while (!(ba_rd || ba_wr) && n < 10) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(ba_rd | ba_wr), 32'd1);
  endtask

  logic [1:0]    expOrder[6];
  int            nOrder;
  logic [DW-1:0] lastDout;

  initial begin
    rst_n      = 1'b0;
    cl_req     = '0;
    cl_wr      = '0;
    cl_addr    = '0;
    cl_din     = '0;
    cl_dsn     = '1;
    ba_ack     = 1'b0;
    ba_rdy     = 1'b0;
    sdram_dout = '0;
    for (int i = 0; i < NCL; i++) cl_addr[i*AW +: AW] = AW'(22'h100 + i);

    // 1: reset with everyone requesting
    applyStimulus(4'hF, 4'h0);
    tick();
    tick();
    checkOutput("rst_ba_rd",   32'(ba_rd),   32'd0);
    checkOutput("rst_ba_wr",   32'(ba_wr),   32'd0);
    checkOutput("rst_ba_addr", 32'(ba_addr), 32'd0);
    checkOutput("rst_ba_din",  32'(ba_din),  32'd0);
    checkOutput("rst_ba_dsn",  32'(ba_dsn),  32'h3);
    checkOutput("rst_cl_rdy",  32'(cl_rdy),  32'd0);
    checkOutput("rst_cl_dout", 32'(cl_dout), 32'd0);
    checkOutput("rst_grant",   32'(grant),   32'd3);
    checkOutput("rst_busy",    32'(busy),    32'd0);
    applyStimulus(4'h0, 4'h0);
    rst_n = 1'b1;
    tick();

    // 2: single read from client 2
    cl_addr[2*AW +: AW] = 22'h1234;
    applyStimulus(4'b0100, 4'h0);
    tick();
    checkOutput("rd_ba_rd",   32'(ba_rd),   32'd1);
    checkOutput("rd_ba_wr",   32'(ba_wr),   32'd0);
    checkOutput("rd_ba_addr", 32'(ba_addr), 32'h1234);
    checkOutput("rd_grant",   32'(grant),   32'd2);
    checkOutput("rd_busy",    32'(busy),    32'd1);
    cl_addr[2*AW +: AW] = 22'h3FFF;
    tick();
    checkOutput("rd_hold_addr", 32'(ba_addr), 32'h1234);
    checkOutput("rd_hold_rd",   32'(ba_rd),   32'd1);
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
    checkOutput("rd_ack_drop", 32'(ba_rd), 32'd0);
    checkOutput("rd_wait_rdy", 32'(cl_rdy), 32'd0);
    ba_rdy     = 1'b1;
    sdram_dout = 16'hBEEF;
    tick();
    ba_rdy = 1'b0;
    checkOutput("rd_cl_rdy",  32'(cl_rdy),  32'b0100);
    checkOutput("rd_cl_dout", 32'(cl_dout), 32'hBEEF);
    applyStimulus(4'h0, 4'h0);
    tick();
    checkOutput("rd_rdy_once", 32'(cl_rdy),  32'd0);
    checkOutput("rd_idle",     32'(busy),    32'd0);
    checkOutput("rd_dout_hold",32'(cl_dout), 32'hBEEF);
    lastDout = 16'hBEEF;
    cl_addr[2*AW +: AW] = 22'h102;

    // 3: fairness from a fresh reset with all clients held
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`ifdef JTFRAME_ARB_PRIO0_EN
    expOrder = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3};
    nOrder   = 6;
`else
    expOrder = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    nOrder   = 5;
`endif
    applyStimulus(4'hF, 4'h0);
    for (int i = 0; i < nOrder; i++) begin
      waitStrobe($sformatf("rr_strobe%0d", i));
      checkOutput($sformatf("rr_grant%0d", i), 32'(grant), 32'(expOrder[i]));
      checkOutput($sformatf("rr_addr%0d", i), 32'(ba_addr), 32'h100 + 32'(expOrder[i]));
      ba_ack = 1'b1;
      tick();
      ba_ack     = 1'b0;
      ba_rdy     = 1'b1;
      sdram_dout = 16'hA000 + 16'(i);
      tick();
      ba_rdy = 1'b0;
      checkOutput($sformatf("rr_rdy%0d", i), 32'(cl_rdy), 32'(4'b0001 << expOrder[i]));
      lastDout = 16'hA000 + 16'(i);
    end
    applyStimulus(4'h0, 4'h0);
    tick();
    tick();
    checkOutput("rr_idle", 32'(busy), 32'd0);

    // 4: write from client 1
    cl_din[1*DW +: DW] = 16'h55AA;
    cl_dsn[1*2 +: 2]   = 2'b10;
    applyStimulus(4'b0010, 4'b0010);
    tick();
    checkOutput("wr_ba_wr",  32'(ba_wr),  32'd1);
    checkOutput("wr_ba_rd",  32'(ba_rd),  32'd0);
    checkOutput("wr_ba_din", 32'(ba_din), 32'h55AA);
    checkOutput("wr_ba_dsn", 32'(ba_dsn), 32'h2);
    checkOutput("wr_grant",  32'(grant),  32'd1);
    ba_ack = 1'b1;
    tick();
    ba_ack     = 1'b0;
    ba_rdy     = 1'b1;
    sdram_dout = 16'hDEAD;
    tick();
    ba_rdy = 1'b0;
    checkOutput("wr_cl_rdy",  32'(cl_rdy),  32'b0010);
    checkOutput("wr_cl_dout", 32'(cl_dout), 32'(lastDout));
    applyStimulus(4'h0, 4'h0);
    tick();

    // 5: ack and rdy in the same cycle, client 3 read
    applyStimulus(4'b1000, 4'h0);
    tick();
    checkOutput("same_ba_rd", 32'(ba_rd), 32'd1);
    checkOutput("same_addr",  32'(ba_addr), 32'h103);
    ba_ack     = 1'b1;
    ba_rdy     = 1'b1;
    sdram_dout = 16'h1357;
    tick();
    ba_ack = 1'b0;
    ba_rdy = 1'b0;
    checkOutput("same_cl_rdy",  32'(cl_rdy),  32'b1000);
    checkOutput("same_busy",    32'(busy),    32'd0);
    checkOutput("same_cl_dout", 32'(cl_dout), 32'h1357);
    applyStimulus(4'h0, 4'h0);
    tick();
    checkOutput("same_rdy_off", 32'(cl_rdy), 32'd0);
    checkOutput("same_idle",    32'(busy),   32'd0);

    // 6: reset while waiting, then stale rdy, then a normal request
    applyStimulus(4'b0001, 4'h0);
    tick();
    ba_ack = 1'b1;
    tick();
    ba_ack = 1'b0;
    checkOutput("rstw_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_async_busy",  32'(busy),  32'd0);
    checkOutput("rstw_async_grant", 32'(grant), 32'd3);
    checkOutput("rstw_async_dsn",   32'(ba_dsn), 32'h3);
    applyStimulus(4'h0, 4'h0);
    tick();
    rst_n      = 1'b1;
    ba_rdy     = 1'b1;
    sdram_dout = 16'h9999;
    tick();
    checkOutput("stale_rdy",  32'(cl_rdy), 32'd0);
    checkOutput("stale_busy", 32'(busy),   32'd0);
    tick();
    ba_rdy = 1'b0;
    checkOutput("stale_rdy2", 32'(cl_rdy),  32'd0);
    checkOutput("stale_dout", 32'(cl_dout), 32'd0);
    applyStimulus(4'b0001, 4'h0);
    tick();
    checkOutput("post_ba_rd", 32'(ba_rd),   32'd1);
    checkOutput("post_grant", 32'(grant),   32'd0);
    checkOutput("post_addr",  32'(ba_addr), 32'h100);
    ba_ack = 1'b1;
    tick();
    ba_ack     = 1'b0;
    ba_rdy     = 1'b1;
    sdram_dout = 16'h2468;
    tick();
    ba_rdy = 1'b0;
    checkOutput("post_cl_rdy",  32'(cl_rdy),  32'b0001);
    checkOutput("post_cl_dout", 32'(cl_dout), 32'h2468);
    applyStimulus(4'h0, 4'h0);
    tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  // Structural properties checked every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ba_rd && ba_wr) begin
        nChecks++;
        $error("[TB] FAIL strobe_excl: observed rd=%0b wr=%0b expected not both", ba_rd, ba_wr);
      end
      if (!$onehot0(cl_rdy)) begin
        nChecks++;
        $error("[TB] FAIL rdy_onehot: observed %b expected at most one bit", cl_rdy);
      end
    end
  end

endmodule
